// File: rtl/mdu_pkg.sv
// Shared constants for the EX-stage multiply/divide unit.
//   mdu_op_e        : MDU operation encodings carried on mdu_op (3 bits).
//   MDU_MUL_CYCLES  : default number of cycles busy stays high for mult/multu.
//   MDU_DIV_CYCLES  : default number of cycles busy stays high for div/divu.
//   mdu_state_e     : sequencer states of the unit.
//   mdu_is_arith()  : true for the ops that run multi-cycle (mult/div family).
package mdu_pkg;

    typedef enum logic [2:0] {
        MDUMult  = 3'd0,
        MDUMultu = 3'd1,
        MDUDiv   = 3'd2,
        MDUDivu  = 3'd3,
        MDUMthi  = 3'd4,
        MDUMtlo  = 3'd5,
        MDUNone  = 3'd7
    } mdu_op_e;

    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic mdu_is_arith(input logic [2:0] op);
        return (op == MDUMult) || (op == MDUMultu) ||
               (op == MDUDiv)  || (op == MDUDivu);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Launch/result bundle between the EX stage and the multiply/divide unit.
//   start        : one-cycle launch pulse for an MDU instruction.
//   mdu_op       : operation (mdu_pkg::mdu_op_e encoding; other codes ignored).
//   a, b         : forwarded rs / rt operands.
//   busy         : an operation is in flight.
//   hi, lo       : architectural HI/LO registers (tapped by the EX result mux).
//   protocol_err : sticky flag, set when start arrives while busy (the ID-stage
//                  stall should make this impossible); cleared only by reset.
// Modports: master = EX stage / hazard side, slave = the MDU.
interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        protocol_err;

    modport master (
        output start, mdu_op, a, b,
        input  busy, hi, lo, protocol_err
    );

    modport slave (
        input  start, mdu_op, a, b,
        output busy, hi, lo, protocol_err
    );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// The full 64-bit result is computed combinationally at launch and parked in
// temp registers; a down-counter then keeps busy high for MUL_CYCLES or
// DIV_CYCLES cycles, and HI/LO are committed on the edge busy falls.
// Ports:
//   clk   : system clock, rising edge.
//   reset : asynchronous active-low reset.
//   bus   : mdu_if.slave (start, mdu_op, a, b in; busy, hi, lo, protocol_err out).
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      temp_hi_q;
    logic [31:0]      temp_lo_q;
    logic             temp_wr_q;
    logic             protocol_err_q;

    // Launch-time arithmetic.
    logic signed [63:0] smul;
    logic [63:0]        umul;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic               div_by_zero;
    logic [31:0]        div_n;
    logic [31:0]        div_d;
    logic [31:0]        uquot;
    logic [31:0]        urem;
    logic [31:0]        res_hi_d;
    logic [31:0]        res_lo_d;

    always_comb begin
        smul = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
        umul = {32'd0, bus.a} * {32'd0, bus.b};

        // One unsigned divider serves both div and divu: signed division works
        // on magnitudes and fixes signs afterwards. This also makes
        // 0x80000000 / -1 fall out naturally (|a| = 0x80000000, quotient
        // positive-signed -> 0x80000000) without any overflow special case.
        div_signed  = (bus.mdu_op == MDUDiv);
        a_neg       = div_signed & bus.a[31];
        b_neg       = div_signed & bus.b[31];
        div_by_zero = (bus.b == 32'd0);
        div_n       = a_neg ? (~bus.a + 32'd1) : bus.a;
        // Divisor forced to 1 on zero; the result is discarded anyway.
        div_d       = div_by_zero ? 32'd1 : (b_neg ? (~bus.b + 32'd1) : bus.b);
        uquot       = div_n / div_d;
        urem        = div_n % div_d;

        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
        case (bus.mdu_op)
            MDUMult:  {res_hi_d, res_lo_d} = smul;
            MDUMultu: {res_hi_d, res_lo_d} = umul;
            MDUDiv: begin
                // Quotient truncates toward zero; remainder takes dividend's sign.
                res_lo_d = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
                res_hi_d = a_neg ? (~urem + 32'd1) : urem;
            end
            MDUDivu: begin
                res_lo_d = uquot;
                res_hi_d = urem;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= MDU_IDLE;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            hi_q           <= 32'd0;
            lo_q           <= 32'd0;
            temp_hi_q      <= 32'd0;
            temp_lo_q      <= 32'd0;
            temp_wr_q      <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (bus.start) begin
                        if (mdu_is_arith(bus.mdu_op)) begin
                            temp_hi_q <= res_hi_d;
                            temp_lo_q <= res_lo_d;
                            busy_q    <= 1'b1;
                            state_q   <= MDU_RUN;
                            if ((bus.mdu_op == MDUMult) || (bus.mdu_op == MDUMultu)) begin
                                cnt_q     <= MUL_LOAD;
                                temp_wr_q <= 1'b1;
                            end else begin
                                cnt_q     <= DIV_LOAD;
                                // Divide by zero still runs the full latency but
                                // leaves HI/LO untouched at commit.
                                temp_wr_q <= !div_by_zero;
                            end
                        end else if (bus.mdu_op == MDUMthi) begin
                            hi_q <= bus.a;
                        end else if (bus.mdu_op == MDUMtlo) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                MDU_RUN: begin
                    // A launch while running is dropped; only flag it.
                    if (bus.start) begin
                        protocol_err_q <= 1'b1;
                    end
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        if (temp_wr_q) begin
                            hi_q <= temp_hi_q;
                            lo_q <= temp_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= MDU_IDLE;
                    end
                end
                default: begin
                    state_q <= MDU_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: the stimulus pushes hand-computed HI/LO and busy
// length for every op it issues; a monitor pops and compares whenever an op
// completes (busy falling, or the cycle after an accepted MTHI/MTLO).
module tb_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mdu_if bus ();

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int          busy_cnt;
        logic        prev_busy;
        logic        mt_pend;
        logic [31:0] snap_hi;
        logic [31:0] snap_lo;
        exp_t        e;
        busy_cnt  = 0;
        prev_busy = 1'b0;
        mt_pend   = 1'b0;
        snap_hi   = 32'd0;
        snap_lo   = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_cnt  = 0;
                prev_busy = 1'b0;
                mt_pend   = 1'b0;
            end else begin
                if (mt_pend) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mt_unexpected: got completion expected none");
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, " busy"}, {31'd0, bus.busy}, 32'd0);
                        check({e.name, " hi"}, bus.hi, e.hi);
                        check({e.name, " lo"}, bus.lo, e.lo);
                    end
                    mt_pend = 1'b0;
                end
                if (bus.busy) begin
                    if (!prev_busy) begin
                        snap_hi = bus.hi;
                        snap_lo = bus.lo;
                    end else if (bus.hi !== snap_hi || bus.lo !== snap_lo) begin
                        checks++; errors++;
                        $display("FAIL hold: hi/lo 0x%08h/0x%08h changed while busy, required 0x%08h/0x%08h",
                                 bus.hi, bus.lo, snap_hi, snap_lo);
                    end
                    busy_cnt++;
                end else if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_completion: got busy fall expected none");
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, " cycles"}, 32'(busy_cnt), 32'(e.cycles));
                        check({e.name, " hi"}, bus.hi, e.hi);
                        check({e.name, " lo"}, bus.lo, e.lo);
                    end
                    busy_cnt = 0;
                end
                prev_busy = bus.busy;
                mt_pend = bus.start && !bus.busy &&
                          (bus.mdu_op == MDUMthi || bus.mdu_op == MDUMtlo);
            end
        end
    end

    // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.mdu_op = MDUNone;
    endtask

    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int cyc);
        exp_t e;
        e.name = name; e.hi = ehi; e.lo = elo; e.cycles = cyc;
        sb_q.push_back(e);
        drive(op, a, b);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL %s timeout: busy still 1 after 40 cycles, required 0", name);
        end
    endtask

    initial begin : stimulus
        bus.start  = 1'b0;
        bus.mdu_op = MDUNone;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        reset      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset protocol_err", {31'd0, bus.protocol_err}, 32'd0);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        issue("mult -2*3", MDUMult, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        wait_idle("mult -2*3");
        issue("multu max*max", MDUMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        wait_idle("multu");
        issue("div -7/2", MDUDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        wait_idle("div -7/2");
        issue("divu 7/2", MDUDivu, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        wait_idle("divu 7/2");
        issue("div min/-1", MDUDiv, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
        wait_idle("div min/-1");

        issue("mthi", MDUMthi, 32'h1234, 32'd0, 32'h1234, 32'h80000000, 0);
        issue("mtlo", MDUMtlo, 32'h5678, 32'd0, 32'h1234, 32'h5678, 0);
        issue("divu by 0", MDUDivu, 32'd5, 32'd0, 32'h1234, 32'h5678, 10);
        wait_idle("divu by 0");

        // Undefined op code: nothing must happen.
        drive(3'd6, 32'hDEAD, 32'hBEEF);
        @(posedge clk); #1;
        check("invalid op busy", {31'd0, bus.busy}, 32'd0);
        check("invalid op hi", bus.hi, 32'h1234);
        check("invalid op lo", bus.lo, 32'h5678);

        // Launch while busy is dropped and flagged.
        issue("mult 2*3 with stray start", MDUMult, 32'd2, 32'd3, 32'd0, 32'd6, 5);
        @(posedge clk); #1;
        drive(MDUDivu, 32'd9, 32'd2);
        check("stray start protocol_err", {31'd0, bus.protocol_err}, 32'd1);
        wait_idle("mult 2*3");

        // Reset in the middle of a divide discards it.
        drive(MDUDiv, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 reset = 1'b0;
        #1;
        check("midop reset busy", {31'd0, bus.busy}, 32'd0);
        check("midop reset hi", bus.hi, 32'd0);
        check("midop reset lo", bus.lo, 32'd0);
        check("midop reset protocol_err", {31'd0, bus.protocol_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: the divide is launched in the first cycle busy is low.
        issue("mult 7*8", MDUMult, 32'd7, 32'd8, 32'd0, 32'd56, 5);
        wait_idle("mult 7*8");
        issue("divu 9/2 back-to-back", MDUDivu, 32'd9, 32'd2, 32'd1, 32'd4, 10);
        wait_idle("divu 9/2");

        begin
            int n;
            n = 0;
            while (sb_q.size() != 0 && n < 5) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
